// File: rtl/spi_slave_word_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_slave_word_fifo_if                                     |
// | Description : Fabric-side bundle of the SPI slave: TX FIFO push side,    |
// |               occupancy, RX word strobe and busy indication.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface spi_slave_word_fifo_if #(
    parameter int WORD_WIDTH = 8,
    parameter int TX_DEPTH   = 4
);
    localparam int c_cnt_w = $clog2(TX_DEPTH) + 1;

    logic                  i_TX_DV;
    logic [WORD_WIDTH-1:0] i_TX_Word;
    logic                  o_TX_Ready;
    logic [c_cnt_w-1:0]    o_TX_Count;
    logic                  o_RX_DV;
    logic [WORD_WIDTH-1:0] o_RX_Word;
    logic                  o_Busy;

    // View of the SPI slave itself
    modport slave (
        input  i_TX_DV, i_TX_Word,
        output o_TX_Ready, o_TX_Count, o_RX_DV, o_RX_Word, o_Busy
    );

    // View of the local logic that feeds and drains the slave
    modport master (
        output i_TX_DV, i_TX_Word,
        input  o_TX_Ready, o_TX_Count, o_RX_DV, o_RX_Word, o_Busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_word_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_slave_word_fifo                                        |
// | Description : SPI slave, any mode, configurable word width and bit      |
// |               order, with a TX word FIFO. All SPI pins are resynchronised|
// |               into i_Clk and edge-detected.                              |
// |               Optional sticky error flags: define SPI_SLAVE_ERR_EN.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module spi_slave_word_fifo #(
    parameter int                    SPI_MODE     = 0,
    parameter int                    WORD_WIDTH   = 8,
    parameter int                    LSB_FIRST    = 0,
    parameter int                    TX_DEPTH     = 4,
    parameter logic [WORD_WIDTH-1:0] TX_IDLE_WORD = '0
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_L,
    spi_slave_word_fifo_if.slave      bus,
    input  logic                      i_SPI_Clk,
    input  logic                      i_SPI_MOSI,
    input  logic                      i_SPI_CS_n,
    output logic                      o_SPI_MISO
`ifdef SPI_SLAVE_ERR_EN
    ,
    input  logic                      i_Err_Clr,
    output logic                      o_TX_Underrun,
    output logic                      o_TX_Overflow,
    output logic                      o_Frame_Err
`endif
);

    localparam logic c_cpol    = (SPI_MODE >= 2);
    localparam logic c_cpha    = ((SPI_MODE % 2) == 1);
    localparam int   c_aw      = $clog2(TX_DEPTH);
    localparam int   c_cnt_w   = c_aw + 1;
    localparam int   c_bw      = $clog2(WORD_WIDTH);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(TX_DEPTH);
    localparam logic [c_bw-1:0]    c_last_bit = c_bw'(WORD_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                state_q,     state_d;
    logic [2:0]            cs_sync_q,   cs_sync_d;
    logic [2:0]            sclk_sync_q, sclk_sync_d;
    logic [1:0]            mosi_sync_q, mosi_sync_d;
    logic [c_bw-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [WORD_WIDTH-1:0] rx_sr_q,     rx_sr_d;
    logic [WORD_WIDTH-1:0] rx_word_q,   rx_word_d;
    logic                  rx_dv_q,     rx_dv_d;
    logic [WORD_WIDTH-1:0] tx_sr_q,     tx_sr_d;
    logic                  miso_q,      miso_d;
    logic [c_aw-1:0]       wr_ptr_q,    wr_ptr_d;
    logic [c_aw-1:0]       rd_ptr_q,    rd_ptr_d;
    logic [c_cnt_w-1:0]    count_q,     count_d;
    logic [WORD_WIDTH-1:0] mem_q [TX_DEPTH];

    // Bit [1] of each chain is the synchronised level, bit [2] its previous value
    logic w_cs_n, w_cs_fall, w_cs_rise;
    logic w_lead, w_trail, w_sample, w_shift, w_mosi;
    logic w_pop, w_pop_fifo, w_underrun, w_push, w_overflow, w_empty, w_full;
    logic [WORD_WIDTH-1:0] w_pop_word;

    assign w_cs_n    = cs_sync_q[1];
    assign w_cs_fall =  cs_sync_q[2] & ~cs_sync_q[1];
    assign w_cs_rise = ~cs_sync_q[2] &  cs_sync_q[1];
    assign w_mosi    = mosi_sync_q[1];

    // SCLK edges only count while the synchronised chip select is asserted
    assign w_lead   = ~w_cs_n && (sclk_sync_q[2] == c_cpol) && (sclk_sync_q[1] != c_cpol);
    assign w_trail  = ~w_cs_n && (sclk_sync_q[2] != c_cpol) && (sclk_sync_q[1] == c_cpol);
    assign w_sample = c_cpha ? w_trail : w_lead;
    assign w_shift  = c_cpha ? w_lead  : w_trail;

    // A new TX word is needed whenever its first bit has to appear on MISO:
    // at CS fall for CPHA=0, and on any shift edge at a word boundary.
    assign w_pop      = (w_shift && (bit_cnt_q == '0)) || (!c_cpha && w_cs_fall);
    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == c_depth);
    assign w_pop_fifo = w_pop && !w_empty;
    assign w_underrun = w_pop && w_empty;
    // A push into a full FIFO is still accepted when a pop frees a slot the same cycle
    assign w_push     = bus.i_TX_DV && (!w_full || w_pop_fifo);
    assign w_overflow = bus.i_TX_DV && !w_push;
    assign w_pop_word = w_empty ? TX_IDLE_WORD : mem_q[rd_ptr_q];

    assign bus.o_TX_Ready = !w_full;
    assign bus.o_TX_Count = count_q;
    assign bus.o_RX_DV    = rx_dv_q;
    assign bus.o_RX_Word  = rx_word_q;
    assign bus.o_Busy     = (state_q == ST_ACTIVE);
    assign o_SPI_MISO     = i_SPI_CS_n ? 1'bz : miso_q;

    // Next-state logic: synchronisers, FSM, RX shifter, TX shifter, FIFO pointers
    always_comb begin
        state_d     = state_q;
        cs_sync_d   = {cs_sync_q[1:0], i_SPI_CS_n};
        sclk_sync_d = {sclk_sync_q[1:0], i_SPI_Clk};
        mosi_sync_d = {mosi_sync_q[0], i_SPI_MOSI};
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        rx_word_d   = rx_word_q;
        rx_dv_d     = 1'b0;
        tx_sr_d     = tx_sr_q;
        miso_d      = miso_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop_fifo);

        case (state_q)
            ST_IDLE:   if (w_cs_fall) state_d = ST_ACTIVE;
            ST_ACTIVE: if (w_cs_rise) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // CS rise drops any partial word; otherwise each sample edge adds a bit
        if (w_cs_rise) begin
            bit_cnt_d = '0;
        end else if (w_sample) begin
            if (LSB_FIRST != 0) rx_sr_d = {w_mosi, rx_sr_q[WORD_WIDTH-1:1]};
            else                rx_sr_d = {rx_sr_q[WORD_WIDTH-2:0], w_mosi};
            if (bit_cnt_q == c_last_bit) begin
                bit_cnt_d = '0;
                rx_word_d = rx_sr_d;
                rx_dv_d   = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + c_bw'(1);
            end
        end

        // The shifter keeps the bits still to be sent; the current bit sits in miso_q
        if (w_pop) begin
            if (LSB_FIRST != 0) begin
                miso_d  = w_pop_word[0];
                tx_sr_d = w_pop_word >> 1;
            end else begin
                miso_d  = w_pop_word[WORD_WIDTH-1];
                tx_sr_d = w_pop_word << 1;
            end
        end else if (w_shift) begin
            if (LSB_FIRST != 0) begin
                miso_d  = tx_sr_q[0];
                tx_sr_d = tx_sr_q >> 1;
            end else begin
                miso_d  = tx_sr_q[WORD_WIDTH-1];
                tx_sr_d = tx_sr_q << 1;
            end
        end

        if (w_push)     wr_ptr_d = wr_ptr_q + c_aw'(1);
        if (w_pop_fifo) rd_ptr_d = rd_ptr_q + c_aw'(1);
    end

    // Control and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            cs_sync_q   <= 3'b111;
            sclk_sync_q <= {3{c_cpol}};
            mosi_sync_q <= 2'b00;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            rx_word_q   <= '0;
            rx_dv_q     <= 1'b0;
            tx_sr_q     <= '0;
            miso_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            rx_word_q   <= rx_word_d;
            rx_dv_q     <= rx_dv_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count
    always_ff @(posedge i_Clk) begin
        if (w_push) mem_q[wr_ptr_q] <= bus.i_TX_Word;
    end

`ifdef SPI_SLAVE_ERR_EN
    logic underrun_q, underrun_d;
    logic overflow_q, overflow_d;
    logic frame_q,    frame_d;

    assign o_TX_Underrun = underrun_q;
    assign o_TX_Overflow = overflow_q;
    assign o_Frame_Err   = frame_q;

    // Sticky flags: a new event wins over a clear in the same cycle
    always_comb begin
        underrun_d = w_underrun | (underrun_q & ~i_Err_Clr);
        overflow_d = w_overflow | (overflow_q & ~i_Err_Clr);
        frame_d    = (w_cs_rise && (bit_cnt_q != '0)) | (frame_q & ~i_Err_Clr);
    end

    // Error flag registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            frame_q    <= frame_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_word_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spi_slave_word_fifo                                     |
// | Description : Directed bench. Instances 0..3 are SPI modes 0..3 (8-bit,  |
// |               MSb first, idle word 0xFF); instance 4 is 16-bit LSb first.|
// |               Error flag checks are built when SPI_SLAVE_ERR_EN is set.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_spi_slave_word_fifo;
    localparam int N    = 5;
    localparam int HALF = 40;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  sclk, mosi, csn, tx_dv;
    logic [15:0]   tx_word [N];
    wire  [N-1:0]  miso, tx_ready, rx_dv, busy;
    wire  [15:0]   rx_word [N];
    wire  [2:0]    tx_count [N];
`ifdef SPI_SLAVE_ERR_EN
    logic [N-1:0]  err_clr;
    wire  [N-1:0]  underrun, overflow, frame_err;
`endif

    int vectors;
    int miscompares;
    int strobes [N];
    logic [15:0] hist [N][8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_mode
        spi_slave_word_fifo_if #(.WORD_WIDTH(8), .TX_DEPTH(4)) bus ();
        assign bus.i_TX_DV   = tx_dv[i];
        assign bus.i_TX_Word = tx_word[i][7:0];
        assign tx_ready[i]   = bus.o_TX_Ready;
        assign tx_count[i]   = bus.o_TX_Count;
        assign rx_dv[i]      = bus.o_RX_DV;
        assign rx_word[i]    = {8'h00, bus.o_RX_Word};
        assign busy[i]       = bus.o_Busy;
        spi_slave_word_fifo #(
            .SPI_MODE(i), .WORD_WIDTH(8), .LSB_FIRST(0), .TX_DEPTH(4), .TX_IDLE_WORD(8'hFF)
        ) u_dut (
            .i_Clk(clk), .i_Rst_L(rst_n), .bus(bus.slave),
            .i_SPI_Clk(sclk[i]), .i_SPI_MOSI(mosi[i]), .i_SPI_CS_n(csn[i]), .o_SPI_MISO(miso[i])
`ifdef SPI_SLAVE_ERR_EN
            , .i_Err_Clr(err_clr[i]), .o_TX_Underrun(underrun[i]),
            .o_TX_Overflow(overflow[i]), .o_Frame_Err(frame_err[i])
`endif
        );
    end

    for (genvar i = 4; i < 5; i++) begin : g_wide
        spi_slave_word_fifo_if #(.WORD_WIDTH(16), .TX_DEPTH(4)) bus ();
        assign bus.i_TX_DV   = tx_dv[i];
        assign bus.i_TX_Word = tx_word[i];
        assign tx_ready[i]   = bus.o_TX_Ready;
        assign tx_count[i]   = bus.o_TX_Count;
        assign rx_dv[i]      = bus.o_RX_DV;
        assign rx_word[i]    = bus.o_RX_Word;
        assign busy[i]       = bus.o_Busy;
        spi_slave_word_fifo #(
            .SPI_MODE(0), .WORD_WIDTH(16), .LSB_FIRST(1), .TX_DEPTH(4), .TX_IDLE_WORD(16'h0000)
        ) u_dut (
            .i_Clk(clk), .i_Rst_L(rst_n), .bus(bus.slave),
            .i_SPI_Clk(sclk[i]), .i_SPI_MOSI(mosi[i]), .i_SPI_CS_n(csn[i]), .o_SPI_MISO(miso[i])
`ifdef SPI_SLAVE_ERR_EN
            , .i_Err_Clr(err_clr[i]), .o_TX_Underrun(underrun[i]),
            .o_TX_Overflow(overflow[i]), .o_Frame_Err(frame_err[i])
`endif
        );
    end

    // Log every RX strobe cycle; a strobe held two cycles shows up as two entries
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rx_dv[i] === 1'b1) begin
                hist[i][strobes[i] % 8] <= rx_word[i];
                strobes[i]              <= strobes[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [15:0] w);
        @(negedge clk);
        tx_dv[idx]   = 1'b1;
        tx_word[idx] = w;
        @(negedge clk);
        tx_dv[idx]   = 1'b0;
    endtask

    task automatic cs_low(input int idx);
        csn[idx] = 1'b0;
        #HALF;
    endtask

    task automatic cs_high(input int idx);
        #HALF;
        csn[idx] = 1'b1;
        #HALF;
    endtask

    // One SPI word (or the first nbits of it) as seen by the master
    task automatic spi_word(input int idx, input logic [15:0] mo, input int nbits,
                            output logic [15:0] mi);
        int   mode;
        int   ww;
        logic cpol;
        logic cpha;
        mode = (idx < 4) ? idx : 0;
        ww   = (idx == 4) ? 16 : 8;
        cpol = (mode >= 2);
        cpha = ((mode % 2) == 1);
        mi   = '0;
        for (int b = 0; b < nbits; b++) begin
            int bp;
            bp = (idx == 4) ? b : (ww - 1 - b);
            if (!cpha) begin
                mosi[idx] = mo[bp];
                #HALF;
                mi[bp]    = miso[idx];
                sclk[idx] = ~cpol;
                #HALF;
                sclk[idx] = cpol;
            end else begin
                sclk[idx] = ~cpol;
                mosi[idx] = mo[bp];
                #HALF;
                mi[bp]    = miso[idx];
                sclk[idx] = cpol;
                #HALF;
            end
        end
    endtask

    initial begin
        logic [15:0] got;
        logic [7:0]  tx_exp [3];
        logic [7:0]  rx_snd [3];
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        sclk        = 5'b01100;
        mosi        = '0;
        csn         = '1;
        tx_dv       = '0;
        for (int i = 0; i < N; i++) tx_word[i] = '0;
`ifdef SPI_SLAVE_ERR_EN
        err_clr     = '0;
`endif
        tx_exp = '{8'h11, 8'h22, 8'h33};
        rx_snd = '{8'h81, 8'h42, 8'h24};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state of every instance
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_rx_dv[%0d]", i),    32'(rx_dv[i]),    32'h0);
            check($sformatf("rst_rx_word[%0d]", i),  32'(rx_word[i]),  32'h0);
            check($sformatf("rst_ready[%0d]", i),    32'(tx_ready[i]), 32'h1);
            check($sformatf("rst_count[%0d]", i),    32'(tx_count[i]), 32'h0);
            check($sformatf("rst_busy[%0d]", i),     32'(busy[i]),     32'h0);
        end

        // Mode 0 single word
        push(0, 16'h00A5);
        check("t1_count_after_push", 32'(tx_count[0]), 32'h1);
        cs_low(0);
        check("t1_busy", 32'(busy[0]), 32'h1);
        spi_word(0, 16'h003C, 8, got);
        cs_high(0);
        check("t1_miso_word", 32'(got), 32'hA5);
        check("t1_strobes", 32'(strobes[0]), 32'h1);
        check("t1_rx_word", 32'(rx_word[0]), 32'h3C);
        check("t1_count_end", 32'(tx_count[0]), 32'h0);
        check("t1_busy_end", 32'(busy[0]), 32'h0);

        // Modes 1..3, three back-to-back words each
        for (int m = 1; m < 4; m++) begin
            for (int k = 0; k < 3; k++) push(m, {8'h00, tx_exp[k]});
            check($sformatf("t2_m%0d_count_full3", m), 32'(tx_count[m]), 32'h3);
            cs_low(m);
            for (int k = 0; k < 3; k++) begin
                spi_word(m, {8'h00, rx_snd[k]}, 8, got);
                check($sformatf("t2_m%0d_miso_w%0d", m, k), 32'(got), 32'(tx_exp[k]));
            end
            cs_high(m);
            check($sformatf("t2_m%0d_strobes", m), 32'(strobes[m]), 32'h3);
            for (int k = 0; k < 3; k++)
                check($sformatf("t2_m%0d_rx_w%0d", m, k), 32'(hist[m][k]), 32'(rx_snd[k]));
            check($sformatf("t2_m%0d_count_end", m), 32'(tx_count[m]), 32'h0);
        end

        // 16-bit, LSb first
        push(4, 16'h8001);
        cs_low(4);
        spi_word(4, 16'h1234, 16, got);
        cs_high(4);
        check("t3_miso_word", 32'(got), 32'h8001);
        check("t3_rx_word", 32'(rx_word[4]), 32'h1234);
        check("t3_strobes", 32'(strobes[4]), 32'h1);

        // Underrun: empty FIFO sends the idle word
`ifdef SPI_SLAVE_ERR_EN
        @(negedge clk); err_clr[0] = 1'b1; @(negedge clk); err_clr[0] = 1'b0;
        check("t4_underrun_cleared", 32'(underrun[0]), 32'h0);
`endif
        cs_low(0);
        spi_word(0, 16'h005A, 8, got);
        cs_high(0);
        check("t4_miso_idle", 32'(got), 32'hFF);
        check("t4_count", 32'(tx_count[0]), 32'h0);
        check("t4_rx_word", 32'(rx_word[0]), 32'h5A);
`ifdef SPI_SLAVE_ERR_EN
        check("t4_underrun", 32'(underrun[0]), 32'h1);
`endif

        // Fill, overflow, push+pop at full, then drain in order
        for (int k = 1; k <= 4; k++) push(0, 16'(k));
        check("t5_count_full", 32'(tx_count[0]), 32'h4);
        check("t5_ready_full", 32'(tx_ready[0]), 32'h0);
`ifdef SPI_SLAVE_ERR_EN
        check("t5_overflow_clear", 32'(overflow[0]), 32'h0);
`endif
        push(0, 16'h0077);
        check("t5_count_after_extra", 32'(tx_count[0]), 32'h4);
`ifdef SPI_SLAVE_ERR_EN
        check("t5_overflow", 32'(overflow[0]), 32'h1);
`endif
        @(negedge clk);
        tx_dv[0]   = 1'b1;
        tx_word[0] = 16'h0005;
        csn[0]     = 1'b0;
        repeat (6) @(negedge clk);
        tx_dv[0]   = 1'b0;
        check("t5_count_push_pop", 32'(tx_count[0]), 32'h4);
        for (int k = 0; k < 5; k++) begin
            spi_word(0, 16'(16'h0010 + 16'(k)), 8, got);
            check($sformatf("t5_miso_w%0d", k), 32'(got), 32'(k + 1));
        end
        cs_high(0);
        check("t5_count_end", 32'(tx_count[0]), 32'h0);
        check("t5_strobes", 32'(strobes[0]), 32'h7);
        check("t5_rx_last", 32'(rx_word[0]), 32'h14);

        // Partial frame, then a good frame
`ifdef SPI_SLAVE_ERR_EN
        @(negedge clk); err_clr[0] = 1'b1; @(negedge clk); err_clr[0] = 1'b0;
        check("t6_frame_err_clear", 32'(frame_err[0]), 32'h0);
`endif
        cs_low(0);
        spi_word(0, 16'h00F0, 5, got);
        cs_high(0);
        check("t6_partial_strobes", 32'(strobes[0]), 32'h7);
        check("t6_partial_rx_word", 32'(rx_word[0]), 32'h14);
`ifdef SPI_SLAVE_ERR_EN
        check("t6_frame_err", 32'(frame_err[0]), 32'h1);
`endif
        push(0, 16'h00C3);
        cs_low(0);
        spi_word(0, 16'h0099, 8, got);
        cs_high(0);
        check("t6_miso_word", 32'(got), 32'hC3);
        check("t6_rx_word", 32'(rx_word[0]), 32'h99);
        check("t6_strobes", 32'(strobes[0]), 32'h8);

        // Asynchronous reset in the middle of a word
        push(0, 16'h0012);
        cs_low(0);
        spi_word(0, 16'h00FF, 3, got);
        check("t7_busy_before", 32'(busy[0]), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t7_rx_dv", 32'(rx_dv[0]), 32'h0);
        check("t7_rx_word", 32'(rx_word[0]), 32'h0);
        check("t7_ready", 32'(tx_ready[0]), 32'h1);
        check("t7_count", 32'(tx_count[0]), 32'h0);
        check("t7_busy", 32'(busy[0]), 32'h0);
`ifdef SPI_SLAVE_ERR_EN
        check("t7_err_flags", 32'({underrun[0], overflow[0], frame_err[0]}), 32'h0);
`endif
        csn[0]  = 1'b1;
        sclk[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t7_strobes_after", 32'(strobes[0]), 32'h8);
        check("t7_busy_after", 32'(busy[0]), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
